exe_muldiv_seq: RTL

//  Iterative multiply/divide sequencer attached to the EXE stage; handles MUL, DIVU, REMU.

---
 rtl/exe_muldiv_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/exe_muldiv_seq.sv
// Iterative multiply/divide sequencer for the EXE stage (MUL, DIVU, REMU).
// One shift-add or restoring-divide step per cycle; the pipeline is frozen
// while an operation is accepted or running.
module exe_muldiv_seq #(
  parameter int unsigned WORD_LEN = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic                flush,
  input  logic [WORD_LEN-1:0] src1,
  input  logic [WORD_LEN-1:0] src2,
  output logic                freeze,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] result,
  output logic                div_by_zero
);

  localparam int unsigned W     = WORD_LEN;
  localparam int unsigned CNT_W = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

  localparam logic [1:0] OP_MUL  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [W-1:0]       opa_q, opa_d;
  logic [W-1:0]       opb_q, opb_d;
  logic [2*W-1:0]     acc_q, acc_d;
  logic [W-1:0]       rem_q, rem_d;
  logic [W-1:0]       result_q, result_d;
  logic               dbz_q, dbz_d;

  logic [W:0]         mul_sum;
  logic [2*W-1:0]     mul_acc_nx;
  logic [W:0]         div_shift;
  logic               div_ge;
  logic [W-1:0]       div_rem_nx;
  logic [W-1:0]       div_quot_nx;

  // Shift-add step: acc = {partial product high, remaining multiplier bits}
  assign mul_sum    = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opa_q} : (W+1)'(0));
  assign mul_acc_nx = {mul_sum, acc_q[W-1:1]};

  // Restoring-divide step: quotient bits shift in from the bottom, MSB first
  assign div_shift   = {rem_q, acc_q[W-1]};
  assign div_ge      = (div_shift >= {1'b0, opb_q});
  assign div_rem_nx  = div_ge ? W'(div_shift - {1'b0, opb_q}) : div_shift[W-1:0];
  assign div_quot_nx = {acc_q[W-2:0], div_ge};

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state, iteration and result capture; flush overrides everything
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = op;
          opa_d = src1;
          opb_d = src2;
          acc_d = {{W{1'b0}}, (op == OP_MUL) ? src2 : src1};
          rem_d = '0;
          if (op == OP_RSVD) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = '0;
            dbz_d    = 1'b0;
          end else if ((op != OP_MUL) && (src2 == '0)) begin
            state_d  = S_DONE;
            cnt_d    = '0;
            result_d = (op == OP_DIVU) ? '1 : src1;
            dbz_d    = 1'b1;
          end else begin
            state_d = S_RUN;
            cnt_d   = CNT_W'(W - 1);
          end
        end
      end
      S_RUN: begin
        if (op_q == OP_MUL) begin
          acc_d = mul_acc_nx;
        end else begin
          acc_d = {{W{1'b0}}, div_quot_nx};
          rem_d = div_rem_nx;
        end
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          dbz_d    = 1'b0;
          result_d = (op_q == OP_MUL)  ? mul_acc_nx[W-1:0] :
                     (op_q == OP_DIVU) ? div_quot_nx : div_rem_nx;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      state_d  = S_IDLE;
      cnt_d    = '0;
      result_d = result_q;
      dbz_d    = dbz_q;
    end
  end

  // Stall drops immediately on flush or reset, without waiting for an edge
  assign freeze      = !rst && !flush &&
                       (((state_q == S_IDLE) && start) || (state_q == S_RUN));
  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE) && !flush;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule
